bcd_tick_counter: RTL and testbench

Downstream consumer of the frequency divider's slow square-wave outputs. It takes one divided signal as an ordinary data input, not as a clock, and synchronizes it into the system clock domain. It detects each rising edge and uses that one-cycle tick to drive a multi-digit BCD up/down counter with synchronous load and a terminal-count pulse. Its outputs feed the display/decoder stage.

---
 rtl/bcd_pkg.sv | 28 ++
 rtl/sync_rise_detect.sv | 33 +++
 rtl/bcd_tick_counter.sv | 67 ++++++
 tb/tb_bcd_tick_counter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD digit constants and per-digit helpers for the tick counter.
// Pure combinational functions; no state lives here.
package bcd_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

    // Returns {carry/borrow out, next digit}; digit is untouched when cin is low.
    function automatic logic [4:0] bcd_step(input logic [3:0] d,
                                            input logic       up,
                                            input logic       cin);
        logic [4:0] r;
        r = {1'b0, d};
        if (cin) begin
            if (up) begin
                r = (d >= BCD_MAX) ? {1'b1, 4'd0} : {1'b0, d + 4'd1};
            end else begin
                r = (d == 4'd0) ? {1'b1, BCD_MAX} : {1'b0, d - 4'd1};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Synchronizes an asynchronous level and flags its rising edges, one cycle each.
// rise asserts SYNC_STAGES clocks after first sampling; no backpressure.
module sync_rise_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   history;
    logic [SYNC_STAGES:0]   fill;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            history <= 1'b0;
            fill    <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
            history <= sync_q[SYNC_STAGES-1];
            fill    <= {fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Armed only once the sync chain and history hold genuine post-reset samples,
    // so a level already high at reset release is never seen as an edge.
    // rise is decoded purely from flops, so it is glitch-free into the counter.
    assign rise = sync_q[SYNC_STAGES-1] & ~history & fill[SYNC_STAGES];

endmodule

// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD up/down counter advanced by synchronized rising edges of tick_in.
// Outputs update SYNC_STAGES clocks after tick_in is first sampled high; no backpressure.
module bcd_tick_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tick_in,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick_pulse,
    output logic                  terminal
);

    localparam int CW = BCD_W * DIGITS;

    logic          rise;
    logic [DIGITS:0] carry;
    logic [CW-1:0] stepped;
    logic [CW-1:0] clamped;

    sync_rise_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (tick_in),
        .rise     (rise)
    );

    assign carry[0] = 1'b1;

    // Ripple carry/borrow: a digit only moves when every lower digit wraps.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [4:0] step;
        assign step                    = bcd_step(count[i*BCD_W +: BCD_W], up_down, carry[i]);
        assign stepped[i*BCD_W +: BCD_W] = step[3:0];
        assign carry[i+1]              = step[4];
        assign clamped[i*BCD_W +: BCD_W] = bcd_clamp(load_value[i*BCD_W +: BCD_W]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count      <= '0;
            tick_pulse <= 1'b0;
            terminal   <= 1'b0;
        end else begin
            tick_pulse <= rise;
            if (load) begin
                count    <= clamped;
                terminal <= 1'b0;
            end else if (enable && rise) begin
                count    <= stepped;
                terminal <= carry[DIGITS];
            end else begin
                terminal <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Scoreboard bench for bcd_tick_counter: decimal reference model, expectations queued per tick.
module tb_bcd_tick_counter;

    localparam int DIGITS      = 4;
    localparam int SYNC_STAGES = 2;
    localparam int CW          = 4 * DIGITS;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          tick_in = 1'b0;
    logic          enable = 1'b0;
    logic          up_down = 1'b1;
    logic          load = 1'b0;
    logic [CW-1:0] load_value = '0;
    logic [CW-1:0] count;
    logic          tick_pulse;
    logic          terminal;

    typedef struct packed {
        logic [CW-1:0] count;
        logic          term;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   model = 0;

    bcd_tick_counter #(
        .DIGITS      (DIGITS),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tick_in    (tick_in),
        .enable     (enable),
        .up_down    (up_down),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .tick_pulse (tick_pulse),
        .terminal   (terminal)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [CW-1:0] to_bcd(input int v);
        logic [CW-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Reference behaviour of one counting tick, queued before the stimulus.
    task automatic push_expect();
        exp_t e;
        e.term = 1'b0;
        if (enable) begin
            if (up_down) begin
                e.term = (model == 9999);
                model  = (model + 1) % 10000;
            end else begin
                e.term = (model == 0);
                model  = (model + 9999) % 10000;
            end
        end
        e.count = to_bcd(model);
        sb.push_back(e);
    endtask

    task automatic wait_pulse(output bit seen, output int cycles);
        seen   = 1'b0;
        cycles = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            cycles++;
            if (tick_pulse === 1'b1) seen = 1'b1;
        end
    endtask

    // Drives one full tick_in period from a negedge; returns what the DUT showed.
    task automatic run_tick(output bit seen, output int lat, output logic [CW-1:0] c_at,
                            output logic t_at, output logic t_next, output int extra);
        int cyc;
        push_expect();
        tick_in = 1'b1;
        wait_pulse(seen, cyc);
        lat   = cyc - 1;
        c_at  = count;
        t_at  = terminal;
        extra = 0;
        @(negedge clock);
        t_next = terminal;
        if (tick_pulse === 1'b1) extra++;
        repeat (2) begin
            @(negedge clock);
            if (tick_pulse === 1'b1) extra++;
        end
        tick_in = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if (tick_pulse === 1'b1) extra++;
        end
    endtask

    task automatic do_load(input logic [CW-1:0] v);
        int d;
        load       = 1'b1;
        load_value = v;
        @(negedge clock);
        load  = 1'b0;
        model = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'(v[i*4 +: 4]);
            if (d > 9) d = 9;
            model = model * 10 + d;
        end
    endtask

    task automatic test_reset();
        int pulses;
        reset = 1'b1; tick_in = 1'b1; enable = 1'b1; up_down = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({count, tick_pulse, terminal} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got count=%h pulse=%b term=%b, want all 0", count, tick_pulse, terminal);
        end
        reset  = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge clock);
            if (tick_pulse === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL reset_release_high: got %0d pulses, want 0", pulses);
        end
        n_cmp++;
        if (count !== to_bcd(0)) begin
            n_bad++;
            $display("FAIL reset_release_count: got %h want %h", count, to_bcd(0));
        end
        tick_in = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    task automatic test_latency_up();
        bit seen; int lat, extra; logic [CW-1:0] c_at; logic t_at, t_next; exp_t e;
        enable = 1'b1; up_down = 1'b1;
        run_tick(seen, lat, c_at, t_at, t_next, extra);
        e = sb.pop_front();
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL latency_pulse: no tick_pulse within 20 clocks");
        end
        n_cmp++;
        if (lat !== SYNC_STAGES) begin
            n_bad++;
            $display("FAIL latency_value: got %0d clocks want %0d", lat, SYNC_STAGES);
        end
        n_cmp++;
        if (c_at !== e.count || t_at !== e.term) begin
            n_bad++;
            $display("FAIL first_count: got %h/%b want %h/%b", c_at, t_at, e.count, e.term);
        end
        n_cmp++;
        if (extra !== 0 || t_next !== 1'b0) begin
            n_bad++;
            $display("FAIL pulse_width: got extra=%0d term_next=%b want 0/0", extra, t_next);
        end
    endtask

    task automatic test_wraps();
        logic [CW-1:0] loads[4];
        logic          dirs[4];
        bit seen; int lat, extra; logic [CW-1:0] c_at; logic t_at, t_next; exp_t e;
        loads[0] = 16'h0009; dirs[0] = 1'b1;
        loads[1] = 16'h9999; dirs[1] = 1'b1;
        loads[2] = 16'h0100; dirs[2] = 1'b0;
        loads[3] = 16'h0000; dirs[3] = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            do_load(loads[k]);
            n_cmp++;
            if (count !== to_bcd(model)) begin
                n_bad++;
                $display("FAIL load_%0d: got %h want %h", k, count, to_bcd(model));
            end
            up_down = dirs[k];
            run_tick(seen, lat, c_at, t_at, t_next, extra);
            e = sb.pop_front();
            n_cmp++;
            if (!seen || c_at !== e.count || t_at !== e.term || t_next !== 1'b0 || extra !== 0) begin
                n_bad++;
                $display("FAIL wrap_%0d: got seen=%b count=%h term=%b term_next=%b extra=%0d want 1/%h/%b/0/0",
                         k, seen, c_at, t_at, t_next, extra, e.count, e.term);
            end
        end
    endtask

    task automatic test_load_priority();
        exp_t e;
        enable = 1'b1; up_down = 1'b1;
        tick_in = 1'b1;
        repeat (SYNC_STAGES) @(negedge clock);
        n_cmp++;
        if (tick_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL prio_early: got pulse=%b want 0", tick_pulse);
        end
        load       = 1'b1;
        load_value = 16'h3A7F;
        model      = 3979;
        e.count    = to_bcd(model);
        e.term     = 1'b0;
        sb.push_back(e);
        @(negedge clock);
        load = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (tick_pulse !== 1'b1 || count !== e.count || terminal !== e.term) begin
            n_bad++;
            $display("FAIL load_priority: got pulse=%b count=%h term=%b want 1/%h/%b",
                     tick_pulse, count, terminal, e.count, e.term);
        end
        repeat (3) @(negedge clock);
        tick_in = 1'b0;
        repeat (5) @(negedge clock);
        n_cmp++;
        if (count !== e.count) begin
            n_bad++;
            $display("FAIL load_hold: got %h want %h", count, e.count);
        end
    endtask

    task automatic test_enable_low();
        bit seen; int lat, extra, pulses; logic [CW-1:0] c_at; logic t_at, t_next; exp_t e;
        enable = 1'b0; up_down = 1'b1;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            run_tick(seen, lat, c_at, t_at, t_next, extra);
            e = sb.pop_front();
            if (seen) pulses++;
            n_cmp++;
            if (c_at !== e.count || t_at !== e.term) begin
                n_bad++;
                $display("FAIL enable_low_%0d: got %h/%b want %h/%b", k, c_at, t_at, e.count, e.term);
            end
        end
        n_cmp++;
        if (pulses !== 3) begin
            n_bad++;
            $display("FAIL enable_low_pulses: got %0d want 3", pulses);
        end
        enable = 1'b1;
    endtask

    task automatic test_async_reset();
        bit seen; int cyc, pulses; exp_t e;
        enable = 1'b1; up_down = 1'b1;
        do_load(16'h1234);
        push_expect();
        tick_in = 1'b1;
        wait_pulse(seen, cyc);
        e = sb.pop_front();
        n_cmp++;
        if (!seen || count !== e.count) begin
            n_bad++;
            $display("FAIL pre_reset_tick: got seen=%b count=%h want 1/%h", seen, count, e.count);
        end
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if ({count, tick_pulse, terminal} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got count=%h pulse=%b term=%b want all 0", count, tick_pulse, terminal);
        end
        model = 0;
        sb.delete();
        repeat (2) @(negedge clock);
        reset  = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge clock);
            if (tick_pulse === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0 || count !== to_bcd(0)) begin
            n_bad++;
            $display("FAIL post_reset: got pulses=%0d count=%h want 0/%h", pulses, count, to_bcd(0));
        end
        tick_in = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_latency_up();
        test_wraps();
        test_load_priority();
        test_enable_low();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
